// File: rtl/itcm_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit ITCM words, zero-fills the
// remaining depth, then releases the core from hold.
module itcm_loader #(
    parameter int          ITCM_DEPTH = 4096,
    parameter int          AW         = $clog2(ITCM_DEPTH),
    parameter logic [31:0] BOOT_PC    = 32'h0000_0080
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          itcm_we,
    output logic [AW-1:0] itcm_addr,
    output logic [31:0]   itcm_wdata,
    output logic          core_hold,
    output logic [31:0]   pc_rtvec,
    output logic          load_done,
    output logic          overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(ITCM_DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t      state, state_nxt;
    logic [AW:0] word_cnt;      // one bit wider so it can hold ITCM_DEPTH
    logic [1:0]  byte_cnt;
    logic [31:0] part;
    logic [31:0] packed_word;
    logic        accept;
    logic        full;

    assign pc_rtvec = BOOT_PC;

    always_comb begin
        s_ready     = (state == LOAD);
        accept      = s_valid && s_ready;
        full        = (word_cnt == DEPTH_W);
        // upper bytes of part are always zero, so a short final word pads itself
        packed_word = part | (32'(s_data) << {byte_cnt, 3'b000});
        state_nxt   = state;
        case (state)
            IDLE:    if (load_start) state_nxt = LOAD;
            LOAD:    if (accept && s_last) state_nxt = FILL;
            FILL:    if (full) state_nxt = DONE;
            DONE:    if (load_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            part       <= '0;
            itcm_we    <= 1'b0;
            itcm_addr  <= '0;
            itcm_wdata <= '0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state   <= state_nxt;
            itcm_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        word_cnt  <= '0;
                        byte_cnt  <= '0;
                        part      <= '0;
                        overflow  <= 1'b0;
                        load_done <= 1'b0;
                        core_hold <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else if (byte_cnt == 2'd3 || s_last) begin
                            itcm_we    <= 1'b1;
                            itcm_addr  <= word_cnt[AW-1:0];
                            itcm_wdata <= packed_word;
                            word_cnt   <= word_cnt + ONE_W;
                            byte_cnt   <= '0;
                            part       <= '0;
                        end else begin
                            part     <= packed_word;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                FILL: begin
                    if (full) begin
                        load_done <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        itcm_we    <= 1'b1;
                        itcm_addr  <= word_cnt[AW-1:0];
                        itcm_wdata <= '0;
                        word_cnt   <= word_cnt + ONE_W;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
